// File: rtl/mmio_timer.sv
// Memory-mapped interval timer on the 8-bit CPU bus: 1-cycle registered reads, toggle-style IRQ.
// Optional missed-service watchdog output O_WDOG is built when MMIO_TIMER_WDOG_EN is defined.
`timescale 1ns/1ps
module mmio_timer #(
    parameter logic [15:0] BASE = 16'hFFF0
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [15:0] I_ADDR,
    input  logic [7:0]  I_DATA,
    input  logic        I_WREN,
    output logic [7:0]  O_DATA,
    output logic        O_SEL,
    output logic        O_IRQ
`ifdef MMIO_TIMER_WDOG_EN
    ,
    output logic        O_WDOG
`endif
);

    localparam logic [2:0] OFF_RELL   = 3'd0;
    localparam logic [2:0] OFF_RELH   = 3'd1;
    localparam logic [2:0] OFF_CTRL   = 3'd2;
    localparam logic [2:0] OFF_STATUS = 3'd3;
    localparam logic [2:0] OFF_CNTL   = 3'd4;
    localparam logic [2:0] OFF_CNTH   = 3'd5;
    localparam logic [2:0] OFF_PRESC  = 3'd6;
    localparam logic [2:0] OFF_EVENTS = 3'd7;

`ifdef MMIO_TIMER_WDOG_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [7:0]  prescale_q, prescale_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  events_q, events_d;
    logic [7:0]  shadow_q, shadow_d;
    logic        exp_q, exp_d;
    logic        irq_q, irq_d;
    logic [7:0]  data_q, data_d;
    logic        sel_q, sel_d;
`ifdef MMIO_TIMER_WDOG_EN
    logic        wdog_q, wdog_d;
`endif

    logic       hit, wr, rd, tick, expire, ctrl_wr, relh_wr;
    logic [2:0] offset;
    logic [7:0] rdata;

    assign hit    = (I_ADDR[15:3] == BASE[15:3]);
    assign offset = I_ADDR[2:0];
    assign wr     = hit && I_WREN;
    assign rd     = hit && !I_WREN;

    assign ctrl_wr = wr && (offset == OFF_CTRL);
    assign relh_wr = wr && (offset == OFF_RELH);
    assign tick    = ctrl_q[0] && (presc_q == prescale_q);
    // Bus writes to CTRL or RELOAD_H in the same cycle take priority over an expiry.
    assign expire  = tick && (count_q == 16'h0000) && !ctrl_wr && !relh_wr;

    always_comb begin
        rdata = 8'h00;
        case (offset)
            OFF_RELL:   rdata = reload_q[7:0];
            OFF_RELH:   rdata = reload_q[15:8];
            OFF_CTRL:   rdata = {4'h0, ctrl_q};
            OFF_STATUS: rdata = {6'h00, ctrl_q[0], exp_q};
            OFF_CNTL:   rdata = count_q[7:0];
            OFF_CNTH:   rdata = shadow_q;
            OFF_PRESC:  rdata = prescale_q;
            OFF_EVENTS: rdata = events_q;
            default:    rdata = 8'h00;
        endcase
    end

    always_comb begin
        reload_d   = reload_q;
        count_d    = count_q;
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        presc_d    = presc_q;
        events_d   = events_q;
        shadow_d   = shadow_q;
        exp_d      = exp_q;
        irq_d      = irq_q;
        sel_d      = hit;
        data_d     = hit ? rdata : 8'h00;

        if (relh_wr) begin
            presc_d = 8'h00;
        end else if (ctrl_q[0]) begin
            presc_d = tick ? 8'h00 : presc_q + 8'd1;
        end

        if (relh_wr) begin
            count_d = {I_DATA, reload_q[7:0]};
        end else if (expire) begin
            count_d = reload_q;
        end else if (tick && (count_q != 16'h0000)) begin
            count_d = count_q - 16'd1;
        end

        if (wr) begin
            case (offset)
                OFF_RELL:  reload_d[7:0]  = I_DATA;
                OFF_RELH:  reload_d[15:8] = I_DATA;
                OFF_CTRL:  ctrl_d         = I_DATA[3:0] & CTRL_MASK;
                OFF_PRESC: prescale_d     = I_DATA;
                default:   ;
            endcase
        end

        if (expire && ctrl_q[1]) ctrl_d[0] = 1'b0;
        if (expire && ctrl_q[2]) irq_d = ~irq_q;

        if (expire) begin
            exp_d = 1'b1;
        end else if (wr && (offset == OFF_STATUS) && I_DATA[0]) begin
            exp_d = 1'b0;
        end

        // A read-clear colliding with an expiry leaves exactly that one new event counted.
        if (rd && (offset == OFF_EVENTS)) begin
            events_d = expire ? ((events_q == 8'hFF) ? 8'hFF : 8'h01) : 8'h00;
        end else if (expire && (events_q != 8'hFF)) begin
            events_d = events_q + 8'd1;
        end

        if (rd && (offset == OFF_CNTL)) shadow_d = count_q[15:8];
    end

`ifdef MMIO_TIMER_WDOG_EN
    assign wdog_d = expire && exp_q && ctrl_q[3];
`endif

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            reload_q   <= 16'h0000;
            count_q    <= 16'h0000;
            ctrl_q     <= 4'h0;
            prescale_q <= 8'h00;
            presc_q    <= 8'h00;
            events_q   <= 8'h00;
            shadow_q   <= 8'h00;
            exp_q      <= 1'b0;
            irq_q      <= 1'b0;
            data_q     <= 8'h00;
            sel_q      <= 1'b0;
`ifdef MMIO_TIMER_WDOG_EN
            wdog_q     <= 1'b0;
`endif
        end else begin
            reload_q   <= reload_d;
            count_q    <= count_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            presc_q    <= presc_d;
            events_q   <= events_d;
            shadow_q   <= shadow_d;
            exp_q      <= exp_d;
            irq_q      <= irq_d;
            data_q     <= data_d;
            sel_q      <= sel_d;
`ifdef MMIO_TIMER_WDOG_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign O_DATA = data_q;
    assign O_SEL  = sel_q;
    assign O_IRQ  = irq_q;
`ifdef MMIO_TIMER_WDOG_EN
    assign O_WDOG = wdog_q;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: bus tasks start and end on a falling clock edge.
`timescale 1ns/1ps
module tb_mmio_timer;

    localparam logic [15:0] BASE = 16'hFFF0;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = IDLE;
    logic [7:0]  wdata = 8'h00;
    logic        wren = 1'b0;
    logic [7:0]  o_data;
    logic        o_sel;
    logic        o_irq;
`ifdef MMIO_TIMER_WDOG_EN
    logic        o_wdog;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mmio_timer #(.BASE(BASE)) dut (
        .CLOCK  (clk),
        .RESET_N(rst_n),
        .I_ADDR (addr),
        .I_DATA (wdata),
        .I_WREN (wren),
        .O_DATA (o_data),
        .O_SEL  (o_sel),
        .O_IRQ  (o_irq)
`ifdef MMIO_TIMER_WDOG_EN
        ,
        .O_WDOG (o_wdog)
`endif
    );

    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        addr  = BASE + {13'h0000, off};
        wdata = d;
        wren  = 1'b1;
        @(negedge clk);
        wren  = 1'b0;
        addr  = IDLE;
    endtask

    task automatic bus_read_addr(input logic [15:0] a, output logic [7:0] d, output logic s);
        addr = a;
        wren = 1'b0;
        @(negedge clk);
        d    = o_data;
        s    = o_sel;
        addr = IDLE;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] d);
        logic s;
        bus_read_addr(BASE + {13'h0000, off}, d, s);
    endtask

    // Returns the number of clocks until O_IRQ changes, or -1 if it does not within limit.
    task automatic wait_toggle(input int limit, output int k);
        logic start;
        start = o_irq;
        k = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (o_irq !== start) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b want=0", o_irq); end
        total++; if (o_sel !== 1'b0) begin bad++; $display("FAIL reset_sel got=%b want=0", o_sel); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", o_data); end
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus_read_addr(BASE + 16'(i), d, s);
            total++;
            if ({s, d} !== 9'h100) begin
                bad++; $display("FAIL reset_read_%0d got sel=%b data=%h want sel=1 data=00", i, s, d);
            end
        end
        bus_read_addr(BASE - 16'd1, d, s);
        total++;
        if ({s, d} !== 9'h000) begin
            bad++; $display("FAIL miss_read got sel=%b data=%h want sel=0 data=00", s, d);
        end
    endtask

    task automatic test_periodic();
        logic [7:0] d;
        int k;
        bus_write(3'd0, 8'h03);
        bus_write(3'd1, 8'h00);
        bus_write(3'd6, 8'h01);
        bus_write(3'd2, 8'h05);
        for (int p = 0; p < 3; p++) begin
            wait_toggle(20, k);
            total++;
            if (k !== 8) begin bad++; $display("FAIL periodic_toggle_%0d got=%0d want=8", p, k); end
        end
        bus_read(3'd7, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL events_after_3 got=%h want=03", d); end
        bus_read(3'd7, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL events_cleared got=%h want=00", d); end
        bus_write(3'd2, 8'h00);
    endtask

    task automatic test_oneshot();
        logic [7:0] d;
        int k;
        bus_write(3'd3, 8'h01);
        bus_read(3'd3, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL status_cleared got=%h want=00", d); end
        bus_write(3'd6, 8'h00);
        bus_write(3'd0, 8'h02);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h07);
        wait_toggle(20, k);
        total++; if (k !== 3) begin bad++; $display("FAIL oneshot_toggle got=%0d want=3", k); end
        wait_toggle(10, k);
        total++; if (k !== -1) begin bad++; $display("FAIL oneshot_extra_toggle got=%0d want=-1", k); end
        bus_read(3'd3, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL oneshot_status got=%h want=01", d); end
        bus_read(3'd2, d);
        total++; if (d !== 8'h06) begin bad++; $display("FAIL oneshot_ctrl got=%h want=06", d); end
        bus_read(3'd4, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL oneshot_count_l got=%h want=02", d); end
        bus_read(3'd5, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL oneshot_count_h got=%h want=00", d); end
    endtask

    task automatic test_w1c_collision();
        logic [7:0] d;
        bus_write(3'd3, 8'h01);
        bus_write(3'd0, 8'h05);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h01);
        // Expiry lands on the 6th edge after the CTRL write; the W1C is placed on that edge.
        repeat (5) @(negedge clk);
        bus_write(3'd3, 8'h01);
        bus_read(3'd3, d);
        total++; if (d !== 8'h03) begin bad++; $display("FAIL w1c_collision_status got=%h want=03", d); end
        bus_write(3'd3, 8'h01);
        bus_read(3'd3, d);
        total++; if (d !== 8'h02) begin bad++; $display("FAIL w1c_later_status got=%h want=02", d); end
        bus_write(3'd2, 8'h00);
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        bus_read(3'd7, d);
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h01);
        repeat (300) @(negedge clk);
        bus_read(3'd7, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL events_saturated got=%h want=ff", d); end
        bus_read(3'd7, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL events_read_on_expiry got=%h want=ff", d); end
        bus_write(3'd2, 8'h00);
        bus_read(3'd7, d);
        total++; if (d !== 8'hFF) begin bad++; $display("FAIL events_after_stop got=%h want=ff", d); end
        bus_read(3'd7, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL events_clear_stopped got=%h want=00", d); end
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h01);
        bus_write(3'd2, 8'h01);
        bus_read(3'd4, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL coherent_l0 got=%h want=00", d); end
        bus_read(3'd5, d);
        total++; if (d !== 8'h01) begin bad++; $display("FAIL coherent_h0 got=%h want=01", d); end
        bus_read(3'd4, d);
        total++; if (d !== 8'hFE) begin bad++; $display("FAIL coherent_l1 got=%h want=fe", d); end
        bus_read(3'd5, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL coherent_h1 got=%h want=00", d); end
        bus_write(3'd2, 8'h00);
    endtask

    task automatic test_ctrl_bit3();
        logic [7:0] d;
        logic [7:0] want;
`ifdef MMIO_TIMER_WDOG_EN
        want = 8'h08;
`else
        want = 8'h00;
`endif
        bus_write(3'd2, 8'h08);
        bus_read(3'd2, d);
        total++; if (d !== want) begin bad++; $display("FAIL ctrl_bit3 got=%h want=%h", d, want); end
        bus_write(3'd2, 8'h00);
    endtask

`ifdef MMIO_TIMER_WDOG_EN
    task automatic test_wdog();
        logic want;
        bus_write(3'd3, 8'h01);
        bus_write(3'd6, 8'h00);
        bus_write(3'd0, 8'h02);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h0D);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            want = (k == 6) || (k == 9);
            total++;
            if (o_wdog !== want) begin bad++; $display("FAIL wdog_cycle_%0d got=%b want=%b", k, o_wdog, want); end
        end
        bus_write(3'd2, 8'h00);
    endtask
`endif

    task automatic test_async_reset();
        logic [7:0] d;
        bit seen;
        bus_write(3'd6, 8'h00);
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h00);
        bus_write(3'd2, 8'h05);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (o_irq === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++; if (seen !== 1'b1) begin bad++; $display("FAIL irq_high_before_reset got=%b want=1", seen); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (o_irq !== 1'b0) begin bad++; $display("FAIL async_reset_irq got=%b want=0", o_irq); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_read(3'd2, d);
        total++; if (d !== 8'h00) begin bad++; $display("FAIL ctrl_after_reset got=%h want=00", d); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_periodic();
        test_oneshot();
        test_w1c_collision();
        test_saturation();
        test_ctrl_bit3();
`ifdef MMIO_TIMER_WDOG_EN
        test_wdog();
`endif
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
